// File: rtl/uart_mem_ctrl.sv
// rtl/uart_mem_ctrl.sv - arbitrates two CPU memory ports onto the host UART byte link
// One transaction at a time: request packet out through the send FIFO, read data back from the receive FIFO.
module uart_mem_ctrl #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_size,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_size,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  input  logic        send_able,
  output logic        send_flag,
  output logic [7:0]  send_data,
  input  logic        recv_able,
  output logic        recv_flag,
  input  logic [7:0]  recv_data
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ADDR, S_WDATA, S_RDATA, S_DONE} state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        rr_pref_q, rr_pref_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic        p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic        gnt;
  logic        tmo_hit;
  logic        last_byte;
  logic [7:0]  header;

  // Size 11 is carried on the wire as 10 (both mean 4 bytes).
  assign header    = {we_q, 4'b0000, port_q, size_q[1], size_q[1] ? 1'b0 : size_q[0]};
  assign last_byte = (size_q == 2'b00) ? 1'b1 :
                     (size_q == 2'b01) ? byte_cnt_q[0] : (byte_cnt_q == 2'b11);

  assign p0_done  = (state_q == S_DONE) && !port_q;
  assign p1_done  = (state_q == S_DONE) && port_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;

  always_comb begin
    state_d    = state_q;
    rr_pref_d  = rr_pref_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    acc_d      = acc_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    p0_err_d   = p0_err_q;
    p1_err_d   = p1_err_q;
    send_flag  = 1'b0;
    send_data  = 8'h00;
    recv_flag  = 1'b0;
    gnt        = 1'b0;
    tmo_hit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt = (p0_req && p1_req) ? rr_pref_q : !p0_req;
        if (p0_req || p1_req) begin
          port_d     = gnt;
          rr_pref_d  = !gnt;
          we_d       = gnt ? p1_we    : p0_we;
          addr_d     = gnt ? p1_addr  : p0_addr;
          wdata_d    = gnt ? p1_wdata : p0_wdata;
          size_d     = gnt ? p1_size  : p0_size;
          byte_cnt_d = 2'd0;
          tmo_d      = 32'd0;
          acc_d      = 32'd0;
          state_d    = S_HEADER;
        end else begin
          recv_flag = recv_able;
        end
      end
      S_HEADER: begin
        send_flag = send_able;
        send_data = header;
        if (send_able) begin
          byte_cnt_d = 2'd0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        send_flag = send_able;
        send_data = addr_q[{byte_cnt_q, 3'b000} +: 8];
        if (send_able) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'b11) state_d = we_q ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        send_flag = send_able;
        send_data = wdata_q[{byte_cnt_q, 3'b000} +: 8];
        if (send_able) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) state_d = S_DONE;
        end
      end
      S_RDATA: begin
        recv_flag = recv_able;
        if (recv_able) begin
          acc_d[{byte_cnt_q, 3'b000} +: 8] = recv_data;
          tmo_d      = 32'd0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
            tmo_hit = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Results land in the granted port's registers as DONE is entered, so they are valid with done.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      if (port_q) begin
        p1_rdata_d = acc_d;
        p1_err_d   = tmo_hit;
      end else begin
        p0_rdata_d = acc_d;
        p0_err_d   = tmo_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rr_pref_q  <= 1'b0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      byte_cnt_q <= 2'd0;
      tmo_q      <= 32'd0;
      acc_q      <= 32'd0;
      p0_rdata_q <= 32'd0;
      p1_rdata_q <= 32'd0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_pref_q  <= rr_pref_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      p0_err_q   <= p0_err_d;
      p1_err_q   <= p1_err_d;
    end
  end

endmodule
